tx_iq_axis_buffer: RTL and testbench

Elastic output buffer between TX_phy's I/Q sample outputs and the tx_i_axis / tx_q_axis master ports. It replaces the permanently-high tvalid with a real AXI-Stream handshake. A single write port feeds two independent read ports, one per channel, each with its own tready. The block primes to a start level before streaming, back-pressures TX_phy through ordy, and counts overflow and underrun events.

---
 rtl/tx_iq_axis_buffer.sv | 117 +++++++++++
 tb/tb_tx_iq_axis_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_iq_axis_buffer.sv
// Elastic I/Q output buffer: one write port from TX_phy, two independently
// drained AXI-Stream read ports, with start-level priming and event counters.
module tx_iq_axis_buffer #(
   parameter int DAT_W        = 16,
   parameter int ADDR_W       = 6,
   parameter int START_LEVEL  = 32,
   parameter int AFULL_MARGIN = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ival,
   input  logic [DAT_W-1:0] idat_i,
   input  logic [DAT_W-1:0] idat_q,
   output logic             ordy,
   output logic [DAT_W-1:0] tx_i_axis_tdata,
   output logic             tx_i_axis_tvalid,
   input  logic             tx_i_axis_tready,
   output logic [DAT_W-1:0] tx_q_axis_tdata,
   output logic             tx_q_axis_tvalid,
   input  logic             tx_q_axis_tready,
   output logic             streaming,
   output logic [CNT_W-1:0] overflow_cnt,
   output logic [CNT_W-1:0] underrun_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AFULL_L = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [ADDR_W:0] START_L = (ADDR_W+1)'(START_LEVEL);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {S_FILL, S_STREAM} state_t;

   state_t           state_q, state_d;
   logic [ADDR_W:0]  wp_q, wp_d;
   logic [ADDR_W:0]  rp_i_q, rp_i_d;
   logic [ADDR_W:0]  rp_q_q, rp_q_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic [CNT_W-1:0] unr_q, unr_d;
   logic [2*DAT_W-1:0] mem_q [DEPTH];

   logic [ADDR_W:0] level_i, level_q, level_max;
   logic            wr_en, xfer_i, xfer_q, starved;

   always_comb begin
      level_i   = wp_q - rp_i_q;
      level_q   = wp_q - rp_q_q;
      level_max = (level_i > level_q) ? level_i : level_q;

      // Write admission looks only at registered levels, so a same-cycle read
      // never makes room for an extra sample.
      wr_en = ival && (level_max < DEPTH_L);
      ordy  = (level_max < AFULL_L);

      streaming        = (state_q == S_STREAM);
      tx_i_axis_tvalid = streaming && (level_i != '0);
      tx_q_axis_tvalid = streaming && (level_q != '0);
      tx_i_axis_tdata  = mem_q[rp_i_q[ADDR_W-1:0]][2*DAT_W-1:DAT_W];
      tx_q_axis_tdata  = mem_q[rp_q_q[ADDR_W-1:0]][DAT_W-1:0];

      xfer_i  = tx_i_axis_tvalid && tx_i_axis_tready;
      xfer_q  = tx_q_axis_tvalid && tx_q_axis_tready;
      starved = streaming && ((tx_i_axis_tready && (level_i == '0)) ||
                              (tx_q_axis_tready && (level_q == '0)));

      overflow_cnt = ovf_q;
      underrun_cnt = unr_q;
   end

   always_comb begin
      wp_d    = wp_q;
      rp_i_d  = rp_i_q;
      rp_q_d  = rp_q_q;
      ovf_d   = ovf_q;
      unr_d   = unr_q;
      state_d = state_q;

      if (wr_en) wp_d = wp_q + PTR_ONE;
      if (xfer_i) rp_i_d = rp_i_q + PTR_ONE;
      if (xfer_q) rp_q_d = rp_q_q + PTR_ONE;
      if (ival && !wr_en && (ovf_q != '1)) ovf_d = ovf_q + CNT_ONE;
      if (starved && (unr_q != '1)) unr_d = unr_q + CNT_ONE;

      case (state_q)
         S_FILL:   if (level_i >= START_L) state_d = S_STREAM;
         // Both channels must be empty, so a valid beat is never withdrawn.
         S_STREAM: if ((level_i == '0) && (level_q == '0)) state_d = S_FILL;
         default:  state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         wp_q    <= '0;
         rp_i_q  <= '0;
         rp_q_q  <= '0;
         ovf_q   <= '0;
         unr_q   <= '0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_i_q  <= rp_i_d;
         rp_q_q  <= rp_q_d;
         ovf_q   <= ovf_d;
         unr_q   <= unr_d;
      end
   end

   // Storage is left unreset; stale entries are never exposed with tvalid high.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wp_q[ADDR_W-1:0]] <= {idat_i, idat_q};
   end

endmodule

// File: tb/tb_tx_iq_axis_buffer.sv
// Directed bench for tx_iq_axis_buffer: scoreboard queues fed on accepted
// writes, drained on observed handshakes, plus directed latency/reset checks.
module tb_tx_iq_axis_buffer;

   localparam int DAT_W        = 16;
   localparam int ADDR_W       = 6;
   localparam int DEPTH        = 64;
   localparam int START_LEVEL  = 32;
   localparam int AFULL_MARGIN = 4;
   localparam int CNT_W        = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ival = 1'b0;
   logic [DAT_W-1:0] idat_i = '0;
   logic [DAT_W-1:0] idat_q = '0;
   logic             ordy;
   logic [DAT_W-1:0] tx_i_axis_tdata;
   logic             tx_i_axis_tvalid;
   logic             tx_i_axis_tready = 1'b0;
   logic [DAT_W-1:0] tx_q_axis_tdata;
   logic             tx_q_axis_tvalid;
   logic             tx_q_axis_tready = 1'b0;
   logic             streaming;
   logic [CNT_W-1:0] overflow_cnt;
   logic [CNT_W-1:0] underrun_cnt;

   always #5 clk = ~clk;

   tx_iq_axis_buffer #(
      .DAT_W(DAT_W), .ADDR_W(ADDR_W), .START_LEVEL(START_LEVEL),
      .AFULL_MARGIN(AFULL_MARGIN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .ival(ival), .idat_i(idat_i), .idat_q(idat_q),
      .ordy(ordy),
      .tx_i_axis_tdata(tx_i_axis_tdata), .tx_i_axis_tvalid(tx_i_axis_tvalid),
      .tx_i_axis_tready(tx_i_axis_tready),
      .tx_q_axis_tdata(tx_q_axis_tdata), .tx_q_axis_tvalid(tx_q_axis_tvalid),
      .tx_q_axis_tready(tx_q_axis_tready),
      .streaming(streaming), .overflow_cnt(overflow_cnt), .underrun_cnt(underrun_cnt)
   );

   logic [DAT_W-1:0] exp_i_q[$];
   logic [DAT_W-1:0] exp_q_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_wr = 0, n_rd_i = 0, n_rd_q = 0, model_ovf = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model of the buffer fill, advanced from stimulus and observed handshakes.
   always @(negedge clk) begin
      int lvl_i, lvl_q, lvl_max;
      logic [DAT_W-1:0] e;
      if (rst) begin
         exp_i_q.delete();
         exp_q_q.delete();
         n_wr = 0; n_rd_i = 0; n_rd_q = 0; model_ovf = 0;
      end else begin
         lvl_i   = n_wr - n_rd_i;
         lvl_q   = n_wr - n_rd_q;
         lvl_max = (lvl_i > lvl_q) ? lvl_i : lvl_q;
         check("ordy", 32'(ordy), 32'(lvl_max < DEPTH - AFULL_MARGIN));
         check("overflow_cnt", 32'(overflow_cnt), 32'(model_ovf));
         if (tx_i_axis_tvalid) check("i_valid_nonempty", 32'(lvl_i != 0), 32'd1);
         if (tx_q_axis_tvalid) check("q_valid_nonempty", 32'(lvl_q != 0), 32'd1);
         if (tx_i_axis_tvalid && tx_i_axis_tready) begin
            if (exp_i_q.size() != 0) e = exp_i_q.pop_front(); else e = 'x;
            check("i_data", 32'(tx_i_axis_tdata), 32'(e));
            n_rd_i++;
         end
         if (tx_q_axis_tvalid && tx_q_axis_tready) begin
            if (exp_q_q.size() != 0) e = exp_q_q.pop_front(); else e = 'x;
            check("q_data", 32'(tx_q_axis_tdata), 32'(e));
            n_rd_q++;
         end
         if (ival) begin
            if (lvl_max < DEPTH) begin
               exp_i_q.push_back(idat_i);
               exp_q_q.push_back(idat_q);
               n_wr++;
            end else if (model_ovf < (1 << CNT_W) - 1) begin
               model_ovf++;
            end
         end
      end
   end

   task automatic do_reset();
      rst  = 1'b1;
      ival = 1'b0;
      tick();
      check("rst_tvalid_i", 32'(tx_i_axis_tvalid), 32'd0);
      check("rst_tvalid_q", 32'(tx_q_axis_tvalid), 32'd0);
      check("rst_ordy", 32'(ordy), 32'd1);
      check("rst_streaming", 32'(streaming), 32'd0);
      check("rst_overflow", 32'(overflow_cnt), 32'd0);
      check("rst_underrun", 32'(underrun_cnt), 32'd0);
      rst = 1'b0;
   endtask

   task automatic send_burst(input int base, input int n, input bit chk_lat);
      for (int k = 0; k < n; k++) begin
         ival   = 1'b1;
         idat_i = DAT_W'(base + k);
         idat_q = DAT_W'(-(base + k));
         if (chk_lat) check("fill_tvalid_i", 32'(tx_i_axis_tvalid), 32'd0);
         tick();
      end
      ival = 1'b0;
      if (chk_lat) begin
         check("lat_pre_tvalid_i", 32'(tx_i_axis_tvalid), 32'd0);
         check("lat_pre_streaming", 32'(streaming), 32'd0);
         tick();
         check("lat_tvalid_i", 32'(tx_i_axis_tvalid), 32'd1);
         check("lat_tvalid_q", 32'(tx_q_axis_tvalid), 32'd1);
         check("lat_streaming", 32'(streaming), 32'd1);
      end
   endtask

   task automatic wait_idle(input string tag, input int max);
      int c = 0;
      while ((streaming || exp_i_q.size() != 0 || exp_q_q.size() != 0) && c < max) begin
         tick();
         c++;
      end
      check({tag, "_timeout"}, 32'(c < max), 32'd1);
      check({tag, "_i_left"}, 32'(exp_i_q.size()), 32'd0);
      check({tag, "_q_left"}, 32'(exp_q_q.size()), 32'd0);
   endtask

   initial begin
      int n, cyc, rd_q0;

      // 1: prime with 32 samples, full-rate drain, one starved cycle at the end
      tx_i_axis_tready = 1'b1;
      tx_q_axis_tready = 1'b1;
      do_reset();
      send_burst(0, START_LEVEL, 1'b1);
      wait_idle("t1", 200);
      check("t1_underrun", 32'(underrun_cnt), 32'd1);

      // 2: Q ready toggling, writer obeys ordy
      do_reset();
      n = 0;
      cyc = 0;
      while (n < 200 && cyc < 5000) begin
         tx_q_axis_tready = (cyc % 2 == 0);
         if (ordy) begin
            ival   = 1'b1;
            idat_i = DAT_W'(n);
            idat_q = DAT_W'(-n);
            n++;
         end else begin
            ival = 1'b0;
         end
         tick();
         cyc++;
      end
      ival = 1'b0;
      check("t2_sent", 32'(n), 32'd200);
      tx_q_axis_tready = 1'b1;
      wait_idle("t2", 1000);
      check("t2_overflow", 32'(overflow_cnt), 32'd0);

      // 3: Q stalled, 70 writes ignoring ordy
      tx_i_axis_tready = 1'b1;
      tx_q_axis_tready = 1'b0;
      do_reset();
      send_burst(0, 70, 1'b0);
      tick();
      check("t3_overflow", 32'(overflow_cnt), 32'd6);
      check("t3_q_tvalid", 32'(tx_q_axis_tvalid), 32'd1);
      check("t3_q_head", 32'(tx_q_axis_tdata), 32'd0);
      check("t3_ordy", 32'(ordy), 32'd0);
      tx_q_axis_tready = 1'b1;
      wait_idle("t3", 300);

      // 4: drain to empty, then restart with the same latency
      do_reset();
      send_burst(0, 40, 1'b0);
      wait_idle("t4a", 300);
      check("t4_underrun", 32'(underrun_cnt), 32'd1);
      check("t4_streaming", 32'(streaming), 32'd0);
      send_burst(500, START_LEVEL, 1'b1);
      wait_idle("t4b", 300);

      // 5: I stalled for 10 cycles mid-stream, Q keeps moving
      do_reset();
      send_burst(1000, 48, 1'b0);
      tx_i_axis_tready = 1'b0;
      rd_q0 = n_rd_q;
      for (int j = 0; j < 10; j++) begin
         check("t5_hold_tvalid_i", 32'(tx_i_axis_tvalid), 32'd1);
         check("t5_hold_tdata_i", 32'(tx_i_axis_tdata),
               (exp_i_q.size() != 0) ? 32'(exp_i_q[0]) : 32'hxxxx_xxxx);
         tick();
      end
      check("t5_q_moved", 32'(n_rd_q - rd_q0), 32'd10);
      tx_i_axis_tready = 1'b1;
      wait_idle("t5", 300);

      // 6: reset mid-stream with non-zero counters, then clean restart
      tx_q_axis_tready = 1'b0;
      do_reset();
      send_burst(2000, 70, 1'b0);
      tick();
      check("t6_pre_overflow", 32'(overflow_cnt), 32'd6);
      check("t6_pre_streaming", 32'(streaming), 32'd1);
      do_reset();
      tx_q_axis_tready = 1'b1;
      send_burst(3000, START_LEVEL, 1'b1);
      wait_idle("t6", 300);
      check("t6_underrun", 32'(underrun_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
